adc: RTL

- Serial audio ADC control circuit: the receive-side counterpart of the DAC controller on the same board.
- Generates the codec clocks (mclk, sclk, lrck) from the 50 MHz system clock.
- Deserializes the ADC's I2S-format serial output into 16-bit left/right sample pairs.
- Presents each completed stereo pair to the sound subsystem with a one-cycle strobe.

---
 rtl/adc_if.sv | 21 ++
 rtl/adc.sv | 79 +++++++
 2 files changed

// File: rtl/adc_if.sv
// Signal bundle between the audio ADC controller and the codec / sound subsystem.
`timescale 1ns/1ps
interface adc_if;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        valid;
  logic        mclk;
  logic        sclk;
  logic        lrck;
  logic        sdto;

  modport master (
    output sample_l, sample_r, valid, mclk, sclk, lrck,
    input  sdto
  );

  modport slave (
    input  sample_l, sample_r, valid, mclk, sclk, lrck,
    output sdto
  );
endinterface

// File: rtl/adc.sv
// I2S audio ADC receive controller: derives codec clocks from a free-running
// 10-bit counter and deserializes 16-bit left/right pairs with a one-cycle strobe.
`timescale 1ns/1ps
module adc (
  input  logic  clk,
  input  logic  reset_n,
  adc_if.master bus
);

  logic [9:0]  cnt_q,    cnt_d;
  logic [15:0] shift_q,  shift_d;
  logic [15:0] left_q,   left_d;
  logic [15:0] sl_q,     sl_d;
  logic [15:0] sr_q,     sr_d;
  logic        valid_q,  valid_d;
  logic        mclk_q,   sclk_q,   lrck_q;
  logic        sample_pt;
  logic        data_slot;
  logic [15:0] word;

  always_comb begin
    cnt_d     = cnt_q + 10'd1;
    sample_pt = (cnt_q[3:0] == 4'd7);
    data_slot = (cnt_q[8:4] >= 5'd1) && (cnt_q[8:4] <= 5'd16);
    word      = {shift_q[14:0], bus.sdto};

    shift_d = shift_q;
    left_d  = left_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    valid_d = 1'b0;

    if (sample_pt && data_slot) begin
      shift_d = word;
    end
    if (cnt_q == 10'd263) begin
      left_d = word;
    end
    // Right word and held left word land together so the outputs are always one frame's pair.
    if (cnt_q == 10'd775) begin
      sr_d    = word;
      sl_d    = left_q;
      valid_d = 1'b1;
    end
  end

  // Clocks come from the next counter value so sclk rises on the sampling edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      shift_q <= '0;
      left_q  <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      valid_q <= 1'b0;
      mclk_q  <= 1'b0;
      sclk_q  <= 1'b0;
      lrck_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      left_q  <= left_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      valid_q <= valid_d;
      mclk_q  <= cnt_d[1];
      sclk_q  <= cnt_d[3];
      lrck_q  <= cnt_d[9];
    end
  end

  assign bus.sample_l = sl_q;
  assign bus.sample_r = sr_q;
  assign bus.valid    = valid_q;
  assign bus.mclk     = mclk_q;
  assign bus.sclk     = sclk_q;
  assign bus.lrck     = lrck_q;

endmodule
